// File: rtl/serial_codec_pkg.sv
// Shared definitions for the bit-serial Excess-3 / BCD codec.
// Contents: direction encodings, default digit geometry, the FSM state type
// and the digit legality check used on the last bit of every digit.
package serial_codec_pkg;

    localparam logic MODE_XS3_TO_BCD = 1'b0;
    localparam logic MODE_BCD_TO_XS3 = 1'b1;

    localparam int DEF_DIGIT_W   = 4;
    localparam int DEF_OFFSET    = 3;
    localparam int DEF_MAX_DIGIT = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } codec_state_t;

    // v is the raw input code of the completed digit.
    function automatic logic digit_legal(input int v, input logic mode,
                                         input int offset, input int max_digit);
        if (mode == MODE_XS3_TO_BCD)
            return (v >= offset) && (v <= max_digit + offset);
        else
            return (v <= max_digit);
    endfunction

endpackage

// File: rtl/serial_const_addsub.sv
// One-bit serial adder/subtractor against a constant bit, holding the
// carry/borrow register k.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears k)
//   x         : serial operand bit
//   c         : constant bit for this bit position
//   mode      : 0 = subtract (borrow), 1 = add (carry)
//   clear     : first bit of a digit; treat k as 0 so nothing crosses digits
//   enable    : update k this cycle
//   z         : result bit (combinational)
//   k_next    : carry/borrow into the next bit position
module serial_const_addsub
    import serial_codec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic c,
    input  logic mode,
    input  logic clear,
    input  logic enable,
    output logic z,
    output logic k_next
);

    logic k;
    logic k_eff;

    always_comb begin
        k_eff = clear ? 1'b0 : k;
        z     = x ^ c ^ k_eff;
        if (mode == MODE_BCD_TO_XS3)
            k_next = (x & c) | ((x ^ c) & k_eff);
        else
            k_next = (~x & c) | (~(x ^ c) & k_eff);
    end

    always_ff @(posedge clk) begin
        if (rst)
            k <= 1'b0;
        else if (enable)
            k <= k_next;
    end

endmodule

// File: rtl/serial_xs3_bcd_codec.sv
// Bit-serial, LSB-first Excess-3 <-> BCD converter for NDIGITS-digit words.
// Each qualified input bit produces its converted bit in the same cycle.
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   X, In_Valid  : serial code bit and its qualifier (low = stall)
//   Start        : bit 0 of digit 0 of a new word (aborts any word in flight)
//   Mode         : direction, sampled with Start
//   Z, Out_Valid : converted bit and its qualifier
//   Digit_Last, Word_Last : current bit is the MSB of a digit / of the word
//   Err          : completed digit is illegal (with Digit_Last)
//   Word_Err     : sticky illegal-digit flag for the current/last word
//   Digit_Idx    : digit in progress
//   Busy         : word in progress
module serial_xs3_bcd_codec
    import serial_codec_pkg::*;
#(
    parameter  int DIGIT_W   = DEF_DIGIT_W,
    parameter  int OFFSET    = DEF_OFFSET,
    parameter  int MAX_DIGIT = DEF_MAX_DIGIT,
    parameter  int NDIGITS   = 4,
    localparam int BW        = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1,
    localparam int DW        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          X,
    input  logic          In_Valid,
    input  logic          Start,
    input  logic          Mode,
    output logic          Z,
    output logic          Out_Valid,
    output logic          Digit_Last,
    output logic          Word_Last,
    output logic          Err,
    output logic          Word_Err,
    output logic [DW-1:0] Digit_Idx,
    output logic          Busy
);

    localparam logic [DIGIT_W-1:0] OFF_V    = DIGIT_W'(OFFSET);
    localparam logic [BW-1:0]      BIT_LAST = BW'(DIGIT_W - 1);
    localparam logic [DW-1:0]      DIG_LAST = DW'(NDIGITS - 1);

    codec_state_t         state;
    logic [BW-1:0]        bit_r, bit_eff;
    logic [DW-1:0]        dig_r, dig_eff;
    logic                 mode_r, mode_eff;
    logic [DIGIT_W-2:0]   nib_r;
    logic                 word_err_r;
    logic                 qual, start_q, ov, c_bit, clr;
    logic                 digit_last, word_last, legal, err;
    logic                 z_cell;
    // The cell keeps its own carry register; its carry-out is not needed here.
    logic                 k_next_unused;

    always_comb begin
        qual       = In_Valid & ~Rst;
        start_q    = qual & Start;
        ov         = qual & ((state == ST_RUN) | Start);
        // A qualified Start overrides the counters so the restart bit is bit 0.
        bit_eff    = start_q ? '0 : bit_r;
        dig_eff    = start_q ? '0 : dig_r;
        mode_eff   = start_q ? Mode : mode_r;
        c_bit      = OFF_V[bit_eff];
        clr        = (bit_eff == '0);
        digit_last = ov & (bit_eff == BIT_LAST);
        word_last  = digit_last & (dig_eff == DIG_LAST);
        legal      = digit_legal(32'({X, nib_r}), mode_eff, OFFSET, MAX_DIGIT);
        err        = digit_last & ~legal;
    end

    serial_const_addsub u_cell (
        .clk    (Clk),
        .rst    (Rst),
        .x      (X),
        .c      (c_bit),
        .mode   (mode_eff),
        .clear  (clr),
        .enable (ov),
        .z      (z_cell),
        .k_next (k_next_unused)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            bit_r      <= '0;
            dig_r      <= '0;
            mode_r     <= MODE_XS3_TO_BCD;
            nib_r      <= '0;
            word_err_r <= 1'b0;
        end else if (ov) begin
            mode_r <= mode_eff;
            // LSB-first: after DIGIT_W-1 shifts, nib_r[0] holds bit 0.
            nib_r  <= {X, nib_r[DIGIT_W-2:1]};
            if (start_q)
                word_err_r <= err;
            else if (err)
                word_err_r <= 1'b1;
            if (bit_eff == BIT_LAST) begin
                bit_r <= '0;
                dig_r <= (dig_eff == DIG_LAST) ? '0 : dig_eff + DW'(1);
            end else begin
                bit_r <= bit_eff + BW'(1);
                dig_r <= dig_eff;
            end
            state <= word_last ? ST_IDLE : ST_RUN;
        end
    end

    assign Z          = z_cell & ~Rst;
    assign Out_Valid  = ov;
    assign Digit_Last = digit_last;
    assign Word_Last  = word_last;
    assign Err        = err;
    assign Word_Err   = word_err_r;
    assign Digit_Idx  = dig_eff;
    assign Busy       = (state == ST_RUN);

endmodule

// File: doc/serial_xs3_bcd_codec.md
Name: serial_xs3_bcd_codec

Overview:
Bit-serial, LSB-first converter between Excess-3 and BCD for multi-digit words, generalising the single-digit serial Excess-3-to-BCD converter. It takes one code bit per qualified clock and produces the converted bit in the same cycle (Mealy).
- Runtime mode selects direction.
- Digit/word framing, input stalls and invalid-digit detection are handled internally.
- Sits between a serial digit source and a serial BCD/XS3 consumer in the lab datapath.

Parameters:
DIGIT_W, 4, bits per digit (code width).
OFFSET, 3, constant added/subtracted per digit.
MAX_DIGIT, 9, largest legal decimal digit value.
NDIGITS, 4, digits per word; bit count per word = NDIGITS*DIGIT_W.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rst  in  1  synchronous active-high reset.
X  in  1  serial code bit, LSB of each digit first, digit 0 first.
In_Valid  in  1  X is valid this cycle; low = stall, all state holds.
Start  in  1  qualified by In_Valid; marks bit 0 of digit 0 of a new word.
Mode  in  1  0 = XS3->BCD (subtract OFFSET), 1 = BCD->XS3 (add OFFSET); sampled only with Start.
Z  out  1  converted bit for the current X (combinational).
Out_Valid  out  1  Z is meaningful this cycle.
Digit_Last  out  1  current bit is the MSB of a digit.
Word_Last  out  1  current bit is the MSB of digit NDIGITS-1.
Err  out  1  pulse with Digit_Last when the completed digit is illegal.
Word_Err  out  1  registered sticky flag: any illegal digit in the current/last word.
Digit_Idx  out  clog2(NDIGITS)  index of digit in progress.
Busy  out  1  registered; word in progress.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - Clears Busy, bit counter, digit counter, carry/borrow, Mode register, nibble shift register and Word_Err.
  - While Rst=1, combinational outputs Z, Out_Valid, Err, Digit_Last and Word_Last are forced to 0.
  - A reset mid-word abandons the word; no further outputs until the next Start.
- States:
  - IDLE: Busy=0. A bit with In_Valid=1 and Start=0 is ignored (Out_Valid=0).
  - RUN: Busy=1.
- Transitions:
  - IDLE -> RUN on In_Valid & Start.
  - RUN -> IDLE after the bit with Word_Last=1.
  - RUN + In_Valid & Start: abort the current word and restart. That bit is bit 0 of digit 0, Mode is re-sampled, and Word_Err is cleared.
- Effective mode: Mode when Start is qualified this cycle, otherwise the registered Mode.
- Out_Valid = In_Valid & (Busy | Start) & ~Rst.
- Per-bit arithmetic, at bit index b within the digit, with c = OFFSET[b]:
  - Z = X ^ c ^ k, where k is the carry (add) or borrow (sub) register.
  - Add next k = (X&c) | ((X^c)&k).
  - Sub next k = (~X&c) | (~(X^c)&k).
  - k is forced to 0 at bit 0 of every digit. The carry/borrow out of the digit MSB is discarded and never propagates between digits.
- Counters:
  - The bit counter wraps DIGIT_W-1 -> 0 and Digit_Idx increments.
  - Digit_Idx wraps NDIGITS-1 -> 0 at the word end.
  - Digit_Last and Word_Last are combinational from the counters, gated by Out_Valid.
- Legality check on the full digit value v (the stored DIGIT_W-1 bits plus the current X), evaluated on the Digit_Last bit:
  - Mode 0 is legal iff OFFSET <= v <= MAX_DIGIT+OFFSET.
  - Mode 1 is legal iff v <= MAX_DIGIT.
  - Illegal: Err=1 that cycle and Word_Err sets at the edge. Z is still the raw modular result.
- Word_Err holds after the word ends until the next qualified Start or Rst.
- Stall: with In_Valid=0, every register holds, and Out_Valid, Err, Digit_Last and Word_Last are 0.

Decomposition:
- Package serial_codec_pkg:
  - MODE_XS3_TO_BCD=1'b0 and MODE_BCD_TO_XS3=1'b1.
  - Default DIGIT_W, OFFSET and MAX_DIGIT.
  - A function computing the legality check.
- One natural sub-module: serial_const_addsub, the one-bit adder/subtractor cell holding k. It has inputs X, c, mode, clear and enable, and outputs Z and next k.
- The top level holds the counters, mode register, nibble shift register and error logic.

Test Plan:
- Mode 0, one word, digit 0 = XS3 1100, bits 0,0,1,1 -> Z = 1,0,0,1 (BCD 9), Err=0, Digit_Last on the 4th bit.
- Mode 1, digit = BCD 0101, bits 1,0,1,0 -> Z = 0,0,0,1 (XS3 1000); all 10 digits in both modes exhaustively round-trip.
- Mode 0, digit = 0001 -> Err=1 on the 4th bit, Word_Err=1 from the next cycle until the next Start; Mode 1 digit 1010 -> Err=1.
- In_Valid low for 3 cycles between every bit of a 4-digit word -> identical Z sequence, Out_Valid only on valid bits, Word_Last on bit 16.
- Start asserted at bit 6 of a word with Mode flipped -> conversion restarts at digit 0 in the new mode, Word_Err cleared, Digit_Idx=0.
- Rst pulsed at bit 9 -> Busy=0, Out_Valid=0; bits without Start are ignored; the next Start converts correctly from digit 0.
